// File: rtl/shift_right_seq.sv
// Sequential right shifter: accepts operand/amount over valid/ready and shifts one bit per clock,
// returning the result plus a sticky bit (OR of every bit shifted out of position 0).
module shift_right_seq #(
    parameter int unsigned DW = 8,
    parameter int unsigned SW = $clog2(DW),
    parameter int unsigned CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [SW-1:0] n,
    input  logic          arith,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y,
    output logic          sticky,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    localparam logic [CW-1:0] DwCnt = CW'(DW);

    state_t        state_q, state_d;
    logic [DW-1:0] y_q, y_d;
    logic          sticky_q, sticky_d;
    logic          fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_ext;

    assign n_ext = CW'(n);

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        sticky_d = sticky_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_d      = a;
                    sticky_d = 1'b0;
                    fill_d   = arith & a[DW-1];
                    // Saturate so over-range amounts still terminate after DW shifts
                    cnt_d    = (n_ext > DwCnt) ? DwCnt : n_ext;
                    state_d  = (n != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                y_d      = {fill_q, y_q[DW-1:1]};
                sticky_d = sticky_q | y_q[0];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            y_q      <= '0;
            sticky_q <= 1'b0;
            fill_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            sticky_q <= sticky_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

    // All handshake outputs decode from state only, so no input-to-output path exists
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign y         = y_q;
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq (DW=8): directed scenarios plus a scoreboarded
// back-to-back sweep with random output stalls.
module tb_shift_right_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       arith, sticky, busy;
    logic [7:0] a, y;
    logic [2:0] n;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    shift_right_seq #(.DW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .n(n),
        .arith(arith), .out_valid(out_valid), .out_ready(out_ready), .y(y), .sticky(sticky),
        .busy(busy)
    );

    function automatic logic [8:0] model(input logic [7:0] av, input logic [2:0] nv,
                                         input logic ar);
        logic signed [7:0] sa;
        logic [7:0] r, mask;
        sa = av;
        if (ar) r = sa >>> nv;
        else    r = av >> nv;
        mask = (8'd1 << nv) - 8'd1;
        return {r, |(av & mask)};
    endfunction

    task automatic send(input logic [7:0] av, input logic [2:0] nv, input logic ar,
                        output bit ok);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; a = av; n = nv; arith = ar;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        @(posedge clk);
        if (ok) sb.push_back(model(av, nv, ar));
        #1;
        in_valid = 1'b0;
        // Scramble fields after accept; they must have no effect
        a = 8'($urandom); n = 3'($urandom); arith = 1'($urandom);
    endtask

    task automatic wait_out(output int cyc, output bit ok);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = out_valid;
    endtask

    task automatic do_request(input logic [7:0] av, input logic [2:0] nv, input logic ar,
                              input logic [7:0] yexp, input logic sexp, input string tag);
        bit ok, okv;
        int cyc;
        logic [8:0] exp;
        out_ready = 1'b1;
        send(av, nv, ar, ok);
        wait_out(cyc, okv);
        total++;
        if (!ok || !okv || cyc != int'(nv) + 1) begin
            bad++;
            $display("FAIL %s latency: got %0d (accepted=%0d valid=%0d) want %0d",
                     tag, cyc, ok, okv, nv + 1);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1ff;
        total++;
        if ({y, sticky} !== exp || {y, sticky} !== {yexp, sexp}) begin
            bad++;
            $display("FAIL %s result: got y=%h sticky=%b want y=%h sticky=%b",
                     tag, y, sticky, yexp, sexp);
        end
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got in_ready=%b out_valid=%b want 1 0",
                     tag, in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; n = '0; arith = 1'b0;
        #3;
        total++;
        if ({out_valid, y, sticky, busy, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got ov=%b y=%h st=%b busy=%b ir=%b want 0 00 0 0 1",
                     out_valid, y, sticky, busy, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_logical;
        do_request(8'hB6, 3'd3, 1'b0, 8'h16, 1'b1, "logical_b6_3");
    endtask

    task automatic test_arith;
        do_request(8'hB6, 3'd3, 1'b1, 8'hF6, 1'b1, "arith_b6_3");
        do_request(8'h36, 3'd3, 1'b1, 8'h06, 1'b1, "arith_36_3");
    endtask

    task automatic test_zero_max;
        do_request(8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0, "zero_5a");
        do_request(8'h80, 3'd7, 1'b0, 8'h01, 1'b0, "max_80");
        do_request(8'h81, 3'd7, 1'b0, 8'h01, 1'b1, "max_81");
    endtask

    task automatic test_backpressure;
        bit ok, okv;
        int cyc, extra;
        logic [7:0] yh;
        logic sh;
        logic [8:0] exp;
        out_ready = 1'b0;
        send(8'hC3, 3'd5, 1'b1, ok);
        wait_out(cyc, okv);
        yh = y; sh = sticky;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            a = 8'hFF; n = 3'd1; arith = 1'b0;
            total++;
            if (!okv || out_valid !== 1'b1 || y !== yh || sticky !== sh || in_ready !== 1'b0)
            begin
                bad++;
                $display("FAIL stall_hold cyc%0d: got ov=%b y=%h st=%b ir=%b want 1 %h %b 0",
                         i, out_valid, y, sticky, in_ready, yh, sh);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1ff;
        total++;
        if ({y, sticky} !== exp || {y, sticky} !== {8'hFE, 1'b1}) begin
            bad++;
            $display("FAIL stall_result: got y=%h sticky=%b want y=fe sticky=1", y, sticky);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total++;
        if (extra != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_dropped: got extra_valid_cycles=%0d ir=%b want 0 1",
                     extra, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        out_ready = 1'b1;
        send(8'hFF, 3'd6, 1'b0, ok);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, y, sticky, busy} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got ov=%b y=%h st=%b busy=%b want 0 00 0 0",
                     out_valid, y, sticky, busy);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b want 1", in_ready);
        end
        do_request(8'h10, 3'd4, 1'b0, 8'h01, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int nreq = 255 * 16;
        logic [8:0] exp;
        sb.delete();
        while ((idx < nreq || got < nreq) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (idx < nreq) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = 8'(1 + idx / 16);
                n = 3'((idx / 2) % 8);
                arith = 1'(idx % 2);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(a, n, arith));
                idx++;
            end
            if (out_valid && out_ready) begin
                got++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sweep_dup: got y=%h sticky=%b want no output", y, sticky);
                end else begin
                    exp = sb.pop_front();
                    if ({y, sticky} !== exp) begin
                        bad++;
                        $display("FAIL sweep #%0d: got y=%h sticky=%b want y=%h sticky=%b",
                                 got, y, sticky, exp[8:1], exp[0]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (got != nreq || idx != nreq || sb.size() != 0) begin
            bad++;
            $display("FAIL sweep_count: got sent=%0d recv=%0d pending=%0d want %0d %0d 0",
                     idx, got, sb.size(), nreq, nreq);
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_zero_max();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Sequential right shifter, the inverse direction of the combinational left shifter.
- Accepts an operand and a shift amount over a valid/ready handshake, then shifts one bit position per clock.
- Returns the result plus a sticky bit, which is the OR of all bits shifted out.
- Used where area matters more than latency, e.g. denormalising values that were scaled up by the left shifter.

Parameters:
- DW, 8, operand and result width in bits (DW >= 2).
- SW, $clog2(DW), shift-amount width; derived, do not override.
- CW, $clog2(DW+1), internal shift-counter width; derived.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/amount/mode valid
- in_ready  output  1  block can accept a new request
- a  input  DW  operand
- n  input  SW  shift amount
- arith  input  1  1 = arithmetic shift (replicate a[DW-1]); 0 = logical shift (fill with 0)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  DW  shifted result
- sticky  output  1  OR of all bits shifted out of position 0
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset: while rst=1, all of the following hold regardless of clk.
  - state=IDLE; y=0; sticky=0; out_valid=0; busy=0; in_ready=1.
  - The internal counter and the fill bit are cleared.
- Reset mid-operation aborts the request; no partial result is ever presented.
- State machine, three states: IDLE, SHIFT, DONE. Outputs are registered or decoded from state only; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge (accept edge T):
    - y <= a; sticky <= 0; fill <= arith & a[DW-1].
    - Counter <= min(n, DW).
    - Next state is SHIFT if n != 0, else DONE.
- SHIFT: each cycle,
  - y <= {fill, y[DW-1:1]};
  - sticky <= sticky | y[0];
  - counter decrements.
  - When counter reaches 1 on the current edge, next state = DONE.
- DONE:
  - out_valid=1; y and sticky held stable.
  - On out_ready=1 at an edge, next state = IDLE and out_valid drops next cycle.
- Latency: out_valid first rises n+1 cycles after the accept edge (n=0 gives 1 cycle; n=DW-1 gives DW cycles).
- in_ready=0 in SHIFT and DONE. in_valid in those states is ignored, not queued.
- Throughput: one request per n+2 cycles minimum. A new accept is possible on the edge after out_ready is sampled in DONE.
- If n >= DW (only possible when DW is not a power of two), the counter saturates at DW.
  - Result is all fill bits.
  - sticky = OR of the entire operand.
- The input fields a, n and arith are sampled only at the accept edge; later changes have no effect.
- out_valid, once high, stays high with y/sticky constant until the handshake completes (AXI-style stability).

Test Plan (DW=8):
- Logical shift: a=8'hB6, n=3, arith=0, out_ready=1 → out_valid rises 4 cycles after accept; y=8'h16, sticky=1; in_ready returns to 1 one cycle after the out handshake.
- Arithmetic shift: a=8'hB6, n=3, arith=1 → y=8'hF6, sticky=1. Also a=8'h36, n=3, arith=1 → y=8'h06, sticky=1.
- Zero and maximum shift:
  - a=8'h5A, n=0 → out_valid 1 cycle after accept, y=8'h5A, sticky=0.
  - a=8'h80, n=7, logical → y=8'h01, sticky=0.
  - a=8'h81, n=7, logical → y=8'h01, sticky=1.
- Backpressure: complete a request with out_ready=0 for 5 cycles → out_valid, y and sticky are stable the whole time. in_ready=0, and a second in_valid pulse during this window is dropped. A later out_ready=1 completes exactly one transfer.
- Reset mid-shift: accept a=8'hFF, n=6; assert rst asynchronously in the 3rd SHIFT cycle → immediately out_valid=0, y=0, sticky=0, busy=0. After release, in_ready=1 and a fresh request (a=8'h10, n=4) yields y=8'h01, sticky=0.
- Back-to-back sweep: for every a in 1..255, n in 0..7, arith in {0,1}, with random out_ready stalls → y matches the golden right shift and sticky = |(a & ((1<<n)-1)); no request is lost or duplicated.
